blue_filter_stream: RTL

BLUE_FILTER_STREAM -- requirements
Module: blue_filter_stream

---
 rtl/blue_filter_stream_if.sv | 27 ++
 rtl/blue_filter_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/blue_filter_stream_if.sv
// AXI4-Stream pixel channel: 0x00RRGGBB data with end-of-line (tlast) and
// start-of-frame (tuser) sidebands. Clock and reset stay outside the bundle.
interface blue_filter_stream_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    // Producer side of the channel
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    // Consumer side of the channel
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/blue_filter_stream.sv
// Blue-channel filter on an AXI4-Stream video path.
// One output register plus a one-entry skid buffer give one cycle of latency
// at one pixel per clock, with a registered s_axis_tready. Control values are
// captured on each start-of-frame beat so a frame is never filtered with a mix
// of settings. Column/row tracking flags malformed lines and counts frames.
module blue_filter_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        ctrl_enable,
    input  logic [7:0]                  ctrl_threshold,
    input  logic [7:0]                  ctrl_gain,
    input  logic                        err_clr,
    blue_filter_stream_if.slave         s_axis,
    blue_filter_stream_if.master        m_axis,
    output logic [15:0]                 frame_cnt,
    output logic                        err_line
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // IDLE: no frame start seen yet, beats pass through untracked.
    // ACTIVE: line/frame tracking running.
    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    // Pipeline registers
    beat_t   out_q,        out_d;
    logic    out_valid_q,  out_valid_d;
    beat_t   skid_q,       skid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    s_ready_q,    s_ready_d;

    // Control and tracking registers
    state_t        state_q, state_d;
    logic          en_q,    en_d;
    logic [7:0]    th_q,    th_d;
    logic [7:0]    gn_q,    gn_d;
    logic [CW-1:0] col_q,   col_d;
    logic [RW-1:0] row_q,   row_d;
    logic [15:0]   frame_q, frame_d;
    logic          err_q,   err_d;

    logic          in_fire;
    logic          eff_en;
    logic [7:0]    eff_th;
    logic [7:0]    eff_gn;
    beat_t         in_beat;

    // Filter one pixel. The 8x8 product is kept at 16 bits; anything above
    // bit 11 after the >>4 means the result exceeds 255 and saturates.
    function automatic logic [31:0] filter_pixel(
        input logic [23:0] rgb,
        input logic        en,
        input logic [7:0]  th,
        input logic [7:0]  gn
    );
        logic [15:0] prod;
        logic [7:0]  b_sat;
        prod  = 16'(rgb[7:0]) * 16'(gn);
        b_sat = (prod[15:12] != 4'd0) ? 8'hFF : prod[11:4];
        if (!en) begin
            filter_pixel = {8'h00, rgb};
        end else if (rgb[7:0] < th) begin
            filter_pixel = 32'h0000_0000;
        end else begin
            filter_pixel = {8'h00, 1'b0, rgb[23:17], 1'b0, rgb[15:9], b_sat};
        end
    endfunction

    assign in_fire = s_axis.tvalid & s_ready_q;

    // A start-of-frame beat uses the live control values; every other beat
    // uses the ones captured at the last start-of-frame.
    assign eff_en = s_axis.tuser ? ctrl_enable    : en_q;
    assign eff_th = s_axis.tuser ? ctrl_threshold : th_q;
    assign eff_gn = s_axis.tuser ? ctrl_gain      : gn_q;

    assign in_beat.data = filter_pixel(s_axis.tdata[23:0], eff_en, eff_th, eff_gn);
    assign in_beat.last = s_axis.tlast;
    assign in_beat.user = s_axis.tuser;

    // Output register / skid buffer steering and registered ready
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || m_axis.tready) begin
            // Output register is free this cycle: refill from skid first to keep order.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: the beat accepted on the strength of last cycle's ready parks here.
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        s_ready_d = ~skid_valid_d;
    end

    // Pipeline state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            // NOTE: data registers are reset too, so tdata reads zero during reset and buffered pixels are dropped.
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            s_ready_q    <= s_ready_d;
        end
    end

    // Control capture, line/frame tracking and state transition
    always_comb begin
        logic          tracked;
        logic [CW-1:0] col_cur;
        logic [RW-1:0] row_cur;
        logic          err_evt;

        state_d = state_q;
        en_d    = en_q;
        th_d    = th_q;
        gn_d    = gn_q;
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        err_evt = 1'b0;
        tracked = in_fire & ((state_q == ST_ACTIVE) | s_axis.tuser);
        col_cur = s_axis.tuser ? '0 : col_q;
        row_cur = s_axis.tuser ? '0 : row_q;

        if (in_fire && s_axis.tuser) begin
            en_d    = ctrl_enable;
            th_d    = ctrl_threshold;
            gn_d    = ctrl_gain;
            state_d = ST_ACTIVE;
        end

        if (tracked) begin
            err_evt = s_axis.tlast ^ (col_cur == COL_LAST);
            if (s_axis.tlast) begin
                col_d = '0;
                if (row_cur == ROW_LAST) begin
                    row_d   = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    row_d = row_cur + RW'(1);
                end
            end else begin
                // An over-long line holds at the last column until its tlast arrives.
                col_d = (col_cur == COL_LAST) ? col_cur : col_cur + CW'(1);
                row_d = row_cur;
            end
        end

        // A new error wins over a simultaneous clear.
        err_d = (err_q & ~err_clr) | err_evt;
    end

    // Control and tracking register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            th_q    <= 8'h00;
            gn_q    <= 8'h00;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            th_q    <= th_d;
            gn_q    <= gn_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tuser  = out_q.user;
    assign frame_cnt     = frame_q;
    assign err_line      = err_q;

endmodule
